// File: rtl/pc_redirect_unit.sv
// Program-counter generator: owns the PC, forms sequential and branch targets,
// and holds one redirect target while fetch is stalled.
module pc_redirect_unit #(
  parameter int             W        = 64,
  parameter int             OFF_W    = 26,
  parameter int             SHIFT    = 2,
  parameter int             INC      = 4,
  parameter int             ALIGN    = 2,
  parameter logic [W-1:0]   RESET_PC = '0
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             stall_i,
  input  logic             br_valid_i,
  input  logic [1:0]       br_type_i,
  input  logic             br_cond_i,
  input  logic [W-1:0]     br_base_i,
  input  logic [OFF_W-1:0] br_offset_i,
  input  logic [W-1:0]     br_reg_i,
  output logic [W-1:0]     pc_o,
  output logic             redirect_o,
  output logic             pending_o,
  output logic             misalign_err_o
);

  localparam logic [W-1:0] INC_W      = W'(INC);
  localparam logic [W-1:0] ALIGN_MASK = (W'(1) << ALIGN) - W'(1);

  logic [W-1:0] pc_q, pc_d;
  logic [W-1:0] buf_q, buf_d;
  logic         pending_q, pending_d;
  logic         redirect_q, redirect_d;
  logic         err_q, err_d;

  logic         taken_s;
  logic [W-1:0] offset_ext_s;
  logic [W-1:0] raw_target_s;
  logic [W-1:0] target_s;
  logic         misalign_s;

  // Decide whether the resolved branch redirects fetch
  always_comb begin
    taken_s = 1'b0;
    if (br_valid_i) begin
      case (br_type_i)
        2'd0:    taken_s = br_cond_i;
        2'd1:    taken_s = 1'b1;
        2'd2:    taken_s = 1'b1;
        default: taken_s = 1'b0;
      endcase
    end else begin
      taken_s = 1'b0;
    end
  end

  // Form the target; misalignment is judged on the raw value before masking
  always_comb begin
    offset_ext_s = {{(W-OFF_W){br_offset_i[OFF_W-1]}}, br_offset_i};
    if (br_type_i == 2'd2) begin
      raw_target_s = br_reg_i;
    end else begin
      raw_target_s = br_base_i + (offset_ext_s << SHIFT);
    end
    misalign_s = |(raw_target_s & ALIGN_MASK);
    target_s   = raw_target_s & ~ALIGN_MASK;
  end

  // Next-state selection; a fresh taken branch always beats the buffered one
  always_comb begin
    pc_d       = pc_q;
    buf_d      = buf_q;
    pending_d  = pending_q;
    redirect_d = 1'b0;
    err_d      = err_q | (taken_s & misalign_s);
    if (taken_s && !stall_i) begin
      pc_d       = target_s;
      redirect_d = 1'b1;
      pending_d  = 1'b0;
    end else if (taken_s) begin
      buf_d     = target_s;
      pending_d = 1'b1;
    end else if (!stall_i && pending_q) begin
      pc_d       = buf_q;
      redirect_d = 1'b1;
      pending_d  = 1'b0;
    end else if (!stall_i) begin
      pc_d = pc_q + INC_W;
    end else begin
      pc_d = pc_q;
    end
  end

  // State registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pc_q       <= RESET_PC;
      buf_q      <= '0;
      pending_q  <= 1'b0;
      redirect_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      buf_q      <= buf_d;
      pending_q  <= pending_d;
      redirect_q <= redirect_d;
      err_q      <= err_d;
    end
  end

  assign pc_o           = pc_q;
  assign redirect_o     = redirect_q;
  assign pending_o      = pending_q;
  assign misalign_err_o = err_q;

endmodule
